// File: rtl/sum_block_accumulator.sv
// Block accumulator fed by the registered 32-bit adder result.
// Sums a programmable number of samples into a wide accumulator, tracks
// carry-out as a sticky per-block overflow flag, and presents the block total
// over a valid/ready handshake. Samples arriving while no block is open are
// counted (saturating) in drop_cnt.
module sum_block_accumulator #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  block_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_sum,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   len_d;
    logic [ACC_W-1:0]   out_acc_d;
    logic [CNT_W-1:0]   out_count_d;
    logic               overflow_d;
    logic [CNT_W-1:0]   drop_cnt_d;
    logic               busy_d;
    logic               out_valid_d;

    logic [SUM_W-1:0]   sum_w;
    logic [CNT_W-1:0]   count_inc;
    logic               drop_sat;
    logic               start_ok;

    // Datapath helpers: carry-extended add, next count, drop saturation.
    always_comb begin
        sum_w     = {1'b0, acc_q} + SUM_W'(in_sum);
        count_inc = count_q + CNT_W'(1);
        drop_sat  = &drop_cnt_q_view();
        start_ok  = start && (block_len != '0);
    end

    function automatic logic [CNT_W-1:0] drop_cnt_q_view();
        return drop_cnt;
    endfunction

    // Next-state and next-register values for FSM and datapath.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        len_d       = len_q;
        out_acc_d   = out_acc;
        out_count_d = out_count;
        overflow_d  = overflow;
        drop_cnt_d  = drop_cnt;

        unique case (state_q)
            S_IDLE: begin
                // A sample coincident with an accepted start is still a drop.
                if (in_valid && !drop_sat) begin
                    drop_cnt_d = drop_cnt + CNT_W'(1);
                end
                if (start_ok) begin
                    len_d      = block_len;
                    acc_d      = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    state_d    = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    acc_d   = sum_w[ACC_W-1:0];
                    count_d = count_inc;
                    if (sum_w[ACC_W]) begin
                        overflow_d = 1'b1;
                    end
                    if (count_inc == len_q) begin
                        out_acc_d   = sum_w[ACC_W-1:0];
                        out_count_d = count_inc;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (in_valid && !drop_sat) begin
                    drop_cnt_d = drop_cnt + CNT_W'(1);
                end
                // out_valid is high throughout DONE, so ready alone completes it.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = (state_d != S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State and registered outputs; async active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            count_q   <= '0;
            len_q     <= '0;
            out_acc   <= '0;
            out_count <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            len_q     <= len_d;
            out_acc   <= out_acc_d;
            out_count <= out_count_d;
            overflow  <= overflow_d;
            drop_cnt  <= drop_cnt_d;
            busy      <= busy_d;
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_sum_block_accumulator.sv
// Randomized bench for sum_block_accumulator against a transaction-level model.
module tb_sum_block_accumulator;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ACC_W   = 40;
    localparam int unsigned ACC_W33 = 33;
    localparam int unsigned CNT_W   = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [CNT_W-1:0]   block_len = '0;
    logic               in_valid = 1'b0;
    logic [DATA_W-1:0]  in_sum = '0;
    logic               out_ready = 1'b0;

    logic               busy, out_valid, overflow;
    logic [ACC_W-1:0]   out_acc;
    logic [CNT_W-1:0]   out_count, drop_cnt;

    logic               busy33, out_valid33, overflow33;
    logic [ACC_W33-1:0] out_acc33;
    logic [CNT_W-1:0]   out_count33, drop_cnt33;

    int                 n_vec = 0;
    int                 n_err = 0;
    int unsigned        exp_drop = 0;
    int unsigned        vals[$];
    int unsigned        gaps[$];

    sum_block_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .reset(reset), .start(start), .block_len(block_len),
        .in_valid(in_valid), .in_sum(in_sum), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_acc(out_acc), .out_count(out_count),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    sum_block_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W33), .CNT_W(CNT_W)) u_dut33 (
        .clk(clk), .reset(reset), .start(start), .block_len(block_len),
        .in_valid(in_valid), .in_sum(in_sum), .busy(busy33), .out_valid(out_valid33),
        .out_ready(out_ready), .out_acc(out_acc33), .out_count(out_count33),
        .overflow(overflow33), .drop_cnt(drop_cnt33)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_drop();
        if (exp_drop < 255) exp_drop++;
    endtask

    function automatic int unsigned rand_sum();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 | $urandom_range(0, 15);
        return $urandom;
    endfunction

    // One complete block: open, feed len samples (with gaps), hold, handshake.
    task automatic run_block(input int unsigned len, input bit start_drop,
                             input int unsigned wait_cyc, input bit drop_in_wait);
        longint unsigned total = 0;
        logic [63:0]     exp40, exp33;
        logic            ovf40, ovf33;
        int unsigned     g, v;

        start     = 1'b1;
        block_len = CNT_W'(len);
        in_valid  = start_drop;
        in_sum    = 32'hDEAD_BEEF;
        if (start_drop) add_drop();
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        check("busy_open", busy, 1);

        for (int i = 0; i < int'(len); i++) begin
            g = (gaps.size() > i) ? gaps[i] : $urandom_range(0, 2);
            v = (vals.size() > i) ? vals[i] : rand_sum();
            for (int k = 0; k < int'(g); k++) begin
                in_valid  = 1'b0;
                start     = $urandom_range(0, 1);
                block_len = CNT_W'($urandom_range(1, 255));
                tick();
            end
            start    = 1'b0;
            in_valid = 1'b1;
            in_sum   = v;
            total   += longint'(v);
            tick();
            if (i < int'(len) - 1) check("no_early_valid", out_valid, 0);
        end
        in_valid = 1'b0;

        exp40 = total & ((64'd1 << ACC_W) - 1);
        ovf40 = (total >> ACC_W) != 0;
        exp33 = total & ((64'd1 << ACC_W33) - 1);
        ovf33 = (total >> ACC_W33) != 0;

        check("out_valid", out_valid, 1);
        check("out_acc", out_acc, exp40);
        check("out_count", out_count, len);
        check("overflow", overflow, ovf40);
        check("out_acc33", out_acc33, exp33);
        check("overflow33", overflow33, ovf33);

        out_ready = 1'b0;
        for (int w = 0; w < int'(wait_cyc); w++) begin
            in_valid  = drop_in_wait;
            in_sum    = $urandom;
            start     = $urandom_range(0, 1);
            block_len = CNT_W'($urandom_range(1, 255));
            if (drop_in_wait) add_drop();
            tick();
            check("hold_acc", out_acc, exp40);
            check("hold_valid", out_valid, 1);
            check("hold_ovf33", overflow33, ovf33);
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_clear", out_valid, 0);
        check("busy_clear", busy, 0);
        check("drop_cnt", drop_cnt, exp_drop);
        vals.delete();
        gaps.delete();
    endtask

    initial begin
        // Power-on reset.
        #2;
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_drop", drop_cnt, 0);
        #10 reset = 1'b1;
        tick();

        // Basic block 1,2,3,4 back-to-back.
        vals = '{1, 2, 3, 4};
        gaps = '{0, 0, 0, 0};
        run_block(4, 1'b0, 0, 1'b0);

        // Wrap and overflow on the 33-bit instance.
        vals = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        gaps = '{0, 0, 0};
        run_block(3, 1'b0, 0, 1'b0);

        // Backpressure: five held cycles with samples arriving.
        run_block(2, 1'b0, 5, 1'b1);

        // Zero-length start ignored; coincident sample is a drop.
        start     = 1'b1;
        block_len = '0;
        in_valid  = 1'b1;
        add_drop();
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        check("len0_busy", busy, 0);
        check("len0_drop", drop_cnt, exp_drop);
        run_block(3, 1'b1, 1, 1'b0);

        // Gapped input 7,_,_,9,_,11.
        vals = '{7, 9, 11};
        gaps = '{0, 2, 1};
        run_block(3, 1'b0, 0, 1'b0);

        // One-sample block.
        run_block(1, 1'b0, 0, 1'b0);

        // Random blocks.
        for (int b = 0; b < 20; b++) begin
            run_block($urandom_range(1, 8), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // drop_cnt saturates at all-ones.
        for (int i = 0; i < 260; i++) begin
            in_valid = 1'b1;
            in_sum   = $urandom;
            add_drop();
            tick();
        end
        in_valid = 1'b0;
        check("drop_sat", drop_cnt, exp_drop);

        // Mid-block async reset after 3 of 5 samples.
        start     = 1'b1;
        block_len = CNT_W'(5);
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_sum   = 32'h0000_1000;
            tick();
        end
        in_valid = 1'b0;
        #3 reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", out_valid, 0);
        check("arst_acc", u_dut.acc_q, 0);
        check("arst_out_acc", out_acc, 0);
        check("arst_drop", drop_cnt, 0);
        exp_drop = 0;
        #3 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_valid", out_valid, 0);
            check("post_rst_busy", busy, 0);
        end

        // Clean block after reset.
        run_block(2, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
